// File: rtl/shift_left_seq.sv
// Lane-wise left shifter: one 5-bit lane per clock, fill lane inserted at lane 0, result over valid/ready.
// Latency in_shift+1 cycles (1 for out-of-range counts, or for every count with SHIFT_LEFT_ONESHOT_EN); in_ready low until the result is taken.
module shift_left_seq #(
    parameter int LANE_W    = 5,
    parameter int LANES     = 10,
    parameter int MAX_SHIFT = 4,
    parameter int SHIFT_W   = 3,
    localparam int DATA_W   = LANE_W * LANES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [LANE_W-1:0]  in_fill,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHIFT_W-1:0] MAX_SHIFT_C = SHIFT_W'(MAX_SHIFT);
    localparam logic [SHIFT_W-1:0] ONE_C       = SHIFT_W'(1);

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [LANE_W-1:0]    fill_q, fill_d;
    logic [SHIFT_W-1:0]   count_q, count_d;
    logic                 err_q, err_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

`ifdef SHIFT_LEFT_ONESHOT_EN
    logic [DATA_W-1:0]    barrel;

    // Chain of conditional one-lane steps; equals the iterative result for every legal count.
    always_comb begin
        barrel = in_data;
        for (int i = 0; i < MAX_SHIFT; i++) begin
            if (SHIFT_W'(i) < in_shift) begin
                barrel = {barrel[DATA_W-LANE_W-1:0], in_fill};
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        fill_d      = fill_q;
        count_d     = count_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    fill_d     = in_fill;
                    count_d    = in_shift;
                    err_d      = 1'b0;
                    in_ready_d = 1'b0;
                    if (in_shift > MAX_SHIFT_C) begin
                        err_d       = 1'b1;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else if (in_shift == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
`ifdef SHIFT_LEFT_ONESHOT_EN
                        data_d      = barrel;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
`else
                        state_d     = SHIFT;
`endif
                    end
                end
            end
            SHIFT: begin
                data_d  = {data_q[DATA_W-LANE_W-1:0], fill_q};
                count_d = count_q - ONE_C;
                if (count_q == ONE_C) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;

endmodule
